dcache_tcm_responder: RTL
=========================

Name: dcache_tcm_responder

Overview:
- Responder (cache side) of the dcache request port: accepts dcache_req_i_t requests from a load or store unit, or from the prefetch arbiter, and answers with dcache_req_o_t.
- Backed by a small on-chip 64-bit-wide memory mapped at one fixed tag value.
- Used as a deterministic stand-in for the data cache in unit benches, and as a tightly-coupled scratchpad.
- Implements the index-then-tag two-phase protocol, kill, byte-enabled stores and back-to-back pipelined loads.

Parameters:
- ArianeCfg, ariane_pkg::ArianeDefaultConfig, platform config; passed through, unused internally.
- NumWords, 512, memory depth in 64-bit words; power of two, at most 2^(DCACHE_INDEX_WIDTH-3).
- BaseTag, 0, tag value the memory answers to (width DCACHE_TAG_WIDTH).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_port_i  in  dcache_req_i_t  request from the requester.
- req_port_o  out  dcache_req_o_t  gnt / rvalid / rdata back to the requester.
- stall_i  in  1  suppresses grants while high; used for backpressure testing.
- err_o  out  1  one-cycle pulse when a completed tag phase carries a tag other than BaseTag.

Behaviour:
- Word address: waddr = address_index[DCACHE_INDEX_WIDTH-1:3], truncated to log2(NumWords) bits. Byte offset is ignored; data_be selects bytes. data_size is not used.
- Pipeline registers:
  - T (tag stage): valid, waddr, we, wdata, be.
  - R (response stage): valid, rdata.
- data_gnt is combinational: data_req && !stall_i && (!T.valid || tag_valid || kill_req).
- On a grant at cycle N, the request enters T at N+1.
- T.valid at cycle M, completion conditions (checked in this order):
  - kill_req=1: entry dropped. No memory access, no rvalid, no err_o. Kill takes priority over tag_valid.
  - tag_valid=1, address_tag==BaseTag, load: memory read; R loaded; data_rvalid=1 with data_rdata at M+1.
  - tag_valid=1, address_tag==BaseTag, store: bytes with be[i]=1 written at the clock edge ending cycle M. No rvalid, since stores complete on gnt only.
  - tag_valid=1, tag mismatch: no write; err_o=1 at M+1. A load still returns rvalid at M+1 with rdata=0, so the requester never hangs.
  - tag_valid=0 and kill_req=0: T holds its contents and no new grant is given.
- Throughput: a grant in the same cycle T completes is allowed, giving one load per cycle sustained. Load latency is gnt at N, tag at N+1, rvalid at N+2.
- Ordering: a store completing at M is visible to a load whose tag phase is at M+1 or later. A load's read and a store's write never occur in the same cycle, because T holds one entry.
- data_rvalid=0 implies data_rdata=0.
- Reset (rst_ni=0, asynchronous): T.valid=0, R.valid=0, data_rvalid=0, data_rdata=0, err_o=0. data_gnt then follows data_req && !stall_i.
- Memory contents are not reset; reads of never-written words return X in simulation.
- A reset mid-transaction drops the in-flight entry with no rvalid after release.
- Simultaneous kill_req and data_req: the new request may be granted in the same cycle the old one is killed.

Test Plan:
1. Reset, then store wdata=64'hDEAD_BEEF_0123_4567, be=8'hFF, index=0x010, tag=BaseTag; then load index=0x010 -> gnt in the request cycle; rvalid 2 cycles after gnt with rdata=64'hDEAD_BEEF_0123_4567; err_o stays 0.
2. Store be=8'h0F, wdata=64'hFFFF_FFFF_AAAA_AAAA over the word from scenario 1, then load -> rdata=64'hDEAD_BEEF_AAAA_AAAA.
3. Four back-to-back loads at indices 0x00, 0x08, 0x10, 0x18, with tags on consecutive cycles -> gnt high 4 consecutive cycles; rvalid high 4 consecutive cycles in request order.
4. Load granted, then kill_req=1 with tag_valid=1 in the tag cycle -> no rvalid, no err_o; the next load completes normally.
5. Load with tag=BaseTag+1 -> err_o pulses 1 cycle; rvalid with rdata=0. Store with a wrong tag -> memory unchanged on readback.
6. Hold tag_valid=0 for 3 cycles after a grant, with stall_i toggling and data_req held -> no further gnt until the tag arrives. Assert rst_ni=0 while T is valid -> rvalid/err_o stay 0 after reset release.

Source files
------------

// File: rtl/ariane_pkg.sv
// Subset of the platform package: the dcache request/response port types and
// the default platform configuration consumed by the TCM responder.
package ariane_pkg;

    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = 44;

    typedef struct packed {
        logic [63:0] dram_base;
        logic [63:0] dram_length;
    } ariane_cfg_t;

    localparam ariane_cfg_t ArianeDefaultConfig = '{
        dram_base:   64'h0000_0000_8000_0000,
        dram_length: 64'h0000_0000_4000_0000
    };

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [63:0]                   data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [7:0]                    data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;

endpackage

// File: rtl/dcache_tcm_responder.sv
// Cache-side responder of the dcache request port backed by a 64-bit scratchpad.
// Index phase is granted into the tag stage (T); loads answer from the response stage (R).
module dcache_tcm_responder
    import ariane_pkg::*;
#(
    parameter ariane_cfg_t                 ArianeCfg = ArianeDefaultConfig,
    parameter int unsigned                 NumWords  = 512,
    parameter logic [DCACHE_TAG_WIDTH-1:0] BaseTag   = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  dcache_req_i_t req_port_i,
    output dcache_req_o_t req_port_o,
    input  logic          stall_i,
    output logic          err_o
);

    localparam int unsigned AddrW = $clog2(NumWords);

    logic             t_valid;
    logic             t_we;
    logic [AddrW-1:0] t_waddr;
    logic [63:0]      t_wdata;
    logic [7:0]       t_be;

    logic             r_valid;
    logic [63:0]      r_rdata;

    logic [63:0]      mem [NumWords];

    logic             gnt;
    logic             t_leave;
    logic             t_close;
    logic             tag_hit;
    logic             rd_en;
    logic             wr_en;
    logic             mismatch;
    logic [AddrW-1:0] req_waddr;
    logic             unused_ok;

    assign req_waddr = req_port_i.address_index[AddrW+2:3];
    assign tag_hit   = (req_port_i.address_tag == BaseTag);

    // Kill wins over tag_valid; either one frees T so a new grant can land the same cycle.
    assign t_leave  = t_valid && (req_port_i.tag_valid || req_port_i.kill_req);
    assign t_close  = t_valid && req_port_i.tag_valid && !req_port_i.kill_req;
    assign gnt      = req_port_i.data_req && !stall_i && (!t_valid || req_port_i.tag_valid || req_port_i.kill_req);
    assign rd_en    = t_close && !t_we;
    assign wr_en    = t_close && t_we && tag_hit;
    assign mismatch = t_close && !tag_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            t_valid <= 1'b0;
            t_we    <= 1'b0;
            t_waddr <= '0;
            t_wdata <= '0;
            t_be    <= '0;
        end else if (gnt) begin
            t_valid <= 1'b1;
            t_we    <= req_port_i.data_we;
            t_waddr <= req_waddr;
            t_wdata <= req_port_i.data_wdata;
            t_be    <= req_port_i.data_be;
        end else if (t_leave) begin
            t_valid <= 1'b0;
        end
    end

    // Mismatching loads still respond (with zero data) so the requester never hangs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_rdata <= '0;
            err_o   <= 1'b0;
        end else begin
            r_valid <= rd_en;
            r_rdata <= (rd_en && tag_hit) ? mem[t_waddr] : '0;
            err_o   <= mismatch;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (t_be[i]) begin
                    mem[t_waddr][8*i +: 8] <= t_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        req_port_o             = '0;
        req_port_o.data_gnt    = gnt;
        req_port_o.data_rvalid = r_valid;
        req_port_o.data_rdata  = r_rdata;
    end

    assign unused_ok = ^{ArianeCfg, req_port_i.address_index, req_port_i.data_size};

endmodule
